// File: rtl/cnn_pkg.sv
// Shared constants and sequencer state encoding for the quantized MNIST CNN front end.
package cnn_pkg;

  localparam int PIX_BITS   = 8;
  localparam int IMG_PIXELS = 784;
  localparam int ADDR_BITS  = 10;
  localparam int CLASS_BITS = 4;

  localparam logic [ADDR_BITS-1:0]  LAST_IDX  = ADDR_BITS'(IMG_PIXELS - 1);
  localparam logic [CLASS_BITS-1:0] ERR_CLASS = {CLASS_BITS{1'b1}};

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    WAIT   = 3'd3,
    RESULT = 3'd4
  } seq_state_t;

endpackage

// File: rtl/image_buffer.sv
// Single-port image store: one pixel per address, synchronous read with one cycle of latency.
module image_buffer
  import cnn_pkg::*;
(
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [PIX_BITS-1:0]  wdata,
  output logic [PIX_BITS-1:0]  rdata
);

  logic [PIX_BITS-1:0] mem [IMG_PIXELS];

  // Write port and registered read port share the single address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mnist_frame_sequencer.sv
// Buffers one host image, clears the CNN chain, streams pixels to conv1 and returns
// the softmax decision (or a timeout marker) through a valid/ready result port.
module mnist_frame_sequencer
  import cnn_pkg::*;
#(
  parameter int CLR_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PIX_BITS-1:0]   s_data,
  input  logic                  s_last,
  output logic                  core_rst_n,
  output logic [PIX_BITS-1:0]   pix_out,
  output logic                  pix_valid,
  input  logic                  dec_valid,
  input  logic [CLASS_BITS-1:0] decision,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [CLASS_BITS-1:0] r_class,
  output logic                  r_err,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int TO_BITS  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CLR_BITS = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [TO_BITS-1:0]  TO_LAST  = TO_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [CLR_BITS-1:0] CLR_LAST = CLR_BITS'(CLR_CYCLES - 1);

  seq_state_t            state, state_nxt;
  logic [ADDR_BITS-1:0]  idx, idx_nxt;
  logic [CLR_BITS-1:0]   clr_cnt, clr_cnt_nxt;
  logic [TO_BITS-1:0]    to_cnt, to_cnt_nxt;
  logic [CLASS_BITS-1:0] cls_q, cls_nxt;
  logic                  err_q, err_nxt;
  logic                  ferr_q, ferr_nxt;
  logic                  buf_we, buf_re;
  logic [ADDR_BITS-1:0]  buf_addr;
  logic [PIX_BITS-1:0]   buf_rdata;

  image_buffer u_buf (
    .clk   (clk),
    .we    (buf_we),
    .re    (buf_re),
    .addr  (buf_addr),
    .wdata (s_data),
    .rdata (buf_rdata)
  );

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= LOAD;
      idx     <= '0;
      clr_cnt <= '0;
      to_cnt  <= '0;
      cls_q   <= '0;
      err_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      clr_cnt <= clr_cnt_nxt;
      to_cnt  <= to_cnt_nxt;
      cls_q   <= cls_nxt;
      err_q   <= err_nxt;
      ferr_q  <= ferr_nxt;
    end
  end

  // Next-state, counter and buffer-port decode.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    clr_cnt_nxt = clr_cnt;
    to_cnt_nxt  = to_cnt;
    cls_nxt     = cls_q;
    err_nxt     = err_q;
    ferr_nxt    = 1'b0;
    buf_we      = 1'b0;
    buf_re      = 1'b0;
    buf_addr    = idx;
    case (state)
      LOAD: begin
        buf_we = s_valid;
        if (s_valid) begin
          if (idx == LAST_IDX) begin
            // A full frame is used even when the host forgot s_last.
            ferr_nxt    = !s_last;
            idx_nxt     = '0;
            clr_cnt_nxt = '0;
            state_nxt   = CLEAR;
          end else if (s_last) begin
            ferr_nxt = 1'b1;
            idx_nxt  = '0;
          end else begin
            idx_nxt = idx + ADDR_BITS'(1);
          end
        end
      end
      CLEAR: begin
        // Prefetch pixel 0 in the last clear cycle so streaming starts gap-free.
        buf_addr = '0;
        if (clr_cnt == CLR_LAST) begin
          buf_re    = 1'b1;
          idx_nxt   = '0;
          state_nxt = STREAM;
        end else begin
          clr_cnt_nxt = clr_cnt + CLR_BITS'(1);
        end
      end
      STREAM: begin
        buf_addr = idx + ADDR_BITS'(1);
        if (idx == LAST_IDX) begin
          idx_nxt    = '0;
          to_cnt_nxt = '0;
          state_nxt  = WAIT;
        end else begin
          buf_re  = 1'b1;
          idx_nxt = idx + ADDR_BITS'(1);
        end
      end
      WAIT: begin
        if (dec_valid) begin
          cls_nxt   = decision;
          err_nxt   = 1'b0;
          state_nxt = RESULT;
        end else if (to_cnt == TO_LAST) begin
          cls_nxt   = ERR_CLASS;
          err_nxt   = 1'b1;
          state_nxt = RESULT;
        end else begin
          to_cnt_nxt = to_cnt + TO_BITS'(1);
        end
      end
      RESULT: begin
        if (r_ready) begin
          state_nxt = LOAD;
        end else begin
          state_nxt = RESULT;
        end
      end
      default: begin
        state_nxt = LOAD;
        idx_nxt   = '0;
      end
    endcase
  end

  assign s_ready    = (state == LOAD);
  assign busy       = (state != LOAD);
  assign core_rst_n = (state == STREAM) || (state == WAIT) || (state == RESULT);
  assign pix_valid  = (state == STREAM);
  assign pix_out    = pix_valid ? buf_rdata : '0;
  assign r_valid    = (state == RESULT);
  assign r_class    = cls_q;
  assign r_err      = err_q;
  assign frame_err  = ferr_q;

endmodule
